rv_id_stage: RTL
================

# rv_id_stage

Parametrised RV32I/RV64I decode stage with an ID/EX pipeline register, N-source operand forwarding, load-use stall generation and an EBREAK halt state machine. Sits between the fetch stage and the execute stage. Drives register-file read addresses combinationally and registers decoded instruction, PC and resolved operands into EX with one-cycle latency.

## Interface
- XLEN, 32: datapath width; 32 or 64.
- NUM_FWD, 3: number of forwarding sources; slot 0 = EX (highest priority), then MEM, WB, ….
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-low reset.
- in_valid  input  1  iw_in/pc_in hold a valid instruction.
- iw_in  input  32  instruction word from fetch.
- pc_in  input  XLEN  instruction PC from fetch.
- rs1_data, rs2_data  input  XLEN  register-file read data.
- df_en  input  NUM_FWD  per-slot writeback enable.
- df_reg  input  5*NUM_FWD  per-slot destination register, slot i at [5i+4:5i].
- df_data  input  XLEN*NUM_FWD  per-slot writeback data.
- df_ex_is_load  input  1  slot 0 instruction is a load (data not yet available).
- flush  input  1  taken branch/jump from EX; kill the instruction in ID.
- resume  input  1  single-cycle pulse; leave HALTED.
- rs1_reg, rs2_reg  output  5  register-file read addresses, iw_in[19:15], iw_in[24:20] (combinational).
- stall_out  output  1  hold fetch (combinational).
- halted  output  1  FSM in HALTED (registered).
- valid_out, wb_en_out  output  1  registered to EX.
- wb_reg_out  output  5  registered iw[11:7].
- pc_out  output  XLEN; iw_out  output  32; rs1_data_out, rs2_data_out  output  XLEN  registered to EX.

## Operation
- Source usage decode: rs1 used by all opcodes except LUI, AUIPC, JAL; rs2 used by OP, STORE, BRANCH only.
- Forwarding, independent per operand: first slot i (lowest index) with df_en[i]=1, df_reg slot = rsN_reg, rsN_reg≠0 supplies data; otherwise register-file data. x0 always yields 0. rs1 and rs2 may both forward, from same or different slots.
- Load-use hazard: in_valid & df_en[0] & df_ex_is_load & used source matches df_reg slot 0 (≠x0) → stall_out=1, bubble into EX, iw_in not consumed.
- wb_en_out = 0 for STORE, BRANCH, bubbles, and rd=x0; 1 otherwise.
- Bubble: iw_out=32'h0000_0013, valid_out=0, wb_en_out=0, wb_reg_out=0, data outputs 0; pc_out takes pc_in.
- FSM states RUN, HALTED:
  - RUN→HALTED: valid EBREAK (iw_in=32'h0010_0073) accepted; EBREAK itself goes to EX as a bubble.
  - HALTED: every cycle bubble, stall_out=1.
  - HALTED→RUN: resume=1; instruction in ID is accepted that same cycle.
- Priority per cycle: reset > flush > HALTED > load-use stall > normal.
- flush: bubble to EX, stall_out=0, FSM unchanged; a flushed EBREAK does not halt.
- in_valid=0 in RUN: bubble, stall_out=0.

## Timing
- Reset (reset=0, asynchronous): iw_out=0x13, pc_out=0, rs1/rs2_data_out=0, valid_out=0, wb_en_out=0, wb_reg_out=0, halted=0, FSM=RUN; stall_out=0 while reset asserted.
- ID→EX latency: 1 cycle; forwarding resolved in the same cycle as decode.
- Load-use stall lasts exactly one cycle when EX advances the load to MEM; the repeat cycle forwards from slot 1.
- halted asserts the cycle after the EBREAK clock edge; deasserts the cycle after resume.
- Reset mid-stall or mid-halt: all state to reset values, no residual bubble.

## Configuration
- RV_ID_PERF_EN defined: adds outputs stall_cnt and bubble_cnt (32-bit each, reset 0, saturating at 32'hFFFF_FFFF); stall_cnt increments every cycle stall_out=1, bubble_cnt every cycle a bubble enters EX.
- Undefined: counters and ports absent; all other behaviour identical.

## Structure
- Package rv_pkg: opcode localparams (OP, OP_IMM, LOAD, STORE, BRANCH, JAL, JALR, LUI, AUIPC, SYSTEM), NOP and EBREAK encodings, FSM state enum.
- Sub-module rv_fwd_mux (XLEN, NUM_FWD): one operand's priority forwarding select; instantiated twice.

## Test plan
- add x3,x1,x2 with df_en=3'b011, slot0 reg=x1 data=0xAAAA_0000, slot1 reg=x2 data=0x5555 → rs1_data_out=0xAAAA_0000, rs2_data_out=0x5555 next cycle.
- Slot 0 and slot 2 both target x5, rs1=x5 → slot 0 data wins; rs1=x0 with slot0 reg=x0 → rs1_data_out=0.
- lw x4 in EX (df_ex_is_load=1), ID add x6,x4,x7 → stall_out=1 one cycle, iw_out=0x13, valid_out=0; next cycle add issues with slot 1 data.
- EBREAK in ID → bubble to EX, halted=1 next cycle, stall_out=1 until resume pulse; following instruction issues the cycle resume=1.
- flush=1 with EBREAK or load-use hazard in ID → bubble, stall_out=0, halted stays 0.
- sw x2,0(x1) → wb_en_out=0; reset=0 asynchronously mid-halt → all outputs at reset values before next clk edge.

Source files
------------

// File: rtl/rv_pkg.sv
// Shared definitions for the RV32I/RV64I decode stage.
// Contents: major opcode encodings, NOP/EBREAK instruction words, decode-stage FSM
// state type and source-register usage helpers.
package rv_pkg;

  localparam logic [6:0] OP     = 7'h33;
  localparam logic [6:0] OP_IMM = 7'h13;
  localparam logic [6:0] LOAD   = 7'h03;
  localparam logic [6:0] STORE  = 7'h23;
  localparam logic [6:0] BRANCH = 7'h63;
  localparam logic [6:0] JAL    = 7'h6f;
  localparam logic [6:0] JALR   = 7'h67;
  localparam logic [6:0] LUI    = 7'h37;
  localparam logic [6:0] AUIPC  = 7'h17;
  localparam logic [6:0] SYSTEM = 7'h73;

  localparam logic [31:0] NOP    = 32'h0000_0013;
  localparam logic [31:0] EBREAK = 32'h0010_0073;

  typedef enum logic {StRun, StHalted} id_state_e;

  // U-type and JAL carry no rs1 field.
  function automatic logic rs1_used(input logic [6:0] opcode);
    return !(opcode == LUI || opcode == AUIPC || opcode == JAL);
  endfunction

  function automatic logic rs2_used(input logic [6:0] opcode);
    return (opcode == OP || opcode == STORE || opcode == BRANCH);
  endfunction

endpackage

// File: rtl/rv_id_stage_if.sv
// Bus bundle between fetch, register file, forwarding sources, execute and the decode stage.
// Modports: master = environment (fetch/RF/EX side), slave = decode stage.
// With RV_ID_PERF_EN defined, adds stall_cnt/bubble_cnt performance counters.
interface rv_id_stage_if #(
  parameter int unsigned XLEN    = 32,
  parameter int unsigned NUM_FWD = 3
);
  logic                      in_valid;
  logic [31:0]               iw_in;
  logic [XLEN-1:0]           pc_in;
  logic [XLEN-1:0]           rs1_data;
  logic [XLEN-1:0]           rs2_data;
  logic [NUM_FWD-1:0]        df_en;
  logic [5*NUM_FWD-1:0]      df_reg;
  logic [XLEN*NUM_FWD-1:0]   df_data;
  logic                      df_ex_is_load;
  logic                      flush;
  logic                      resume;

  logic [4:0]                rs1_reg;
  logic [4:0]                rs2_reg;
  logic                      stall_out;
  logic                      halted;
  logic                      valid_out;
  logic                      wb_en_out;
  logic [4:0]                wb_reg_out;
  logic [XLEN-1:0]           pc_out;
  logic [31:0]               iw_out;
  logic [XLEN-1:0]           rs1_data_out;
  logic [XLEN-1:0]           rs2_data_out;
`ifdef RV_ID_PERF_EN
  logic [31:0]               stall_cnt;
  logic [31:0]               bubble_cnt;

  modport master (
    output in_valid, iw_in, pc_in, rs1_data, rs2_data, df_en, df_reg, df_data,
           df_ex_is_load, flush, resume,
    input  rs1_reg, rs2_reg, stall_out, halted, valid_out, wb_en_out, wb_reg_out,
           pc_out, iw_out, rs1_data_out, rs2_data_out, stall_cnt, bubble_cnt
  );
  modport slave (
    input  in_valid, iw_in, pc_in, rs1_data, rs2_data, df_en, df_reg, df_data,
           df_ex_is_load, flush, resume,
    output rs1_reg, rs2_reg, stall_out, halted, valid_out, wb_en_out, wb_reg_out,
           pc_out, iw_out, rs1_data_out, rs2_data_out, stall_cnt, bubble_cnt
  );
`else
  modport master (
    output in_valid, iw_in, pc_in, rs1_data, rs2_data, df_en, df_reg, df_data,
           df_ex_is_load, flush, resume,
    input  rs1_reg, rs2_reg, stall_out, halted, valid_out, wb_en_out, wb_reg_out,
           pc_out, iw_out, rs1_data_out, rs2_data_out
  );
  modport slave (
    input  in_valid, iw_in, pc_in, rs1_data, rs2_data, df_en, df_reg, df_data,
           df_ex_is_load, flush, resume,
    output rs1_reg, rs2_reg, stall_out, halted, valid_out, wb_en_out, wb_reg_out,
           pc_out, iw_out, rs1_data_out, rs2_data_out
  );
`endif
endinterface

// File: rtl/rv_fwd_mux.sv
// Priority forwarding select for one source operand.
// Ports: reg_i source register, rf_data_i register-file data, df_en_i/df_reg_i/df_data_i
// per-slot writeback bundle (slot 0 highest priority), data_o resolved operand.
// x0 always resolves to zero regardless of any forwarding slot.
module rv_fwd_mux #(
  parameter int unsigned XLEN    = 32,
  parameter int unsigned NUM_FWD = 3
) (
  input  logic [4:0]              reg_i,
  input  logic [XLEN-1:0]         rf_data_i,
  input  logic [NUM_FWD-1:0]      df_en_i,
  input  logic [5*NUM_FWD-1:0]    df_reg_i,
  input  logic [XLEN*NUM_FWD-1:0] df_data_i,
  output logic [XLEN-1:0]         data_o
);

  always_comb begin
    data_o = rf_data_i;
    // Walk from lowest to highest priority so the lowest matching slot wins.
    for (int i = int'(NUM_FWD) - 1; i >= 0; i--) begin
      if (df_en_i[i] && (df_reg_i[5*i +: 5] == reg_i)) begin
        data_o = df_data_i[XLEN*i +: XLEN];
      end
    end
    if (reg_i == 5'd0) begin
      data_o = '0;
    end
  end

endmodule

// File: rtl/rv_id_stage.sv
// RV32I/RV64I decode stage with ID/EX pipeline register, N-source operand forwarding,
// load-use stall and EBREAK halt FSM.
// Ports: clk (rising edge), reset (async, active-low), bus (rv_id_stage_if.slave):
//   fetch inputs in_valid/iw_in/pc_in, RF data, forwarding bundle df_*, flush, resume;
//   outputs RF read addresses, stall_out, halted and the registered EX-side fields.
// Optional: RV_ID_PERF_EN adds saturating stall_cnt/bubble_cnt counters.
module rv_id_stage
  import rv_pkg::*;
#(
  parameter int unsigned XLEN    = 32,
  parameter int unsigned NUM_FWD = 3
) (
  input  logic          clk,
  input  logic          reset,
  rv_id_stage_if.slave  bus
);

  logic [6:0]      opcode;
  logic [4:0]      rd;
  logic [4:0]      rs1, rs2;
  logic [XLEN-1:0] rs1_fwd, rs2_fwd;
  logic            src1_hit, src2_hit, load_use, is_ebreak;
  logic            stall, issue;

  id_state_e       state_q, state_d;
  logic [31:0]     iw_q, iw_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic [XLEN-1:0] rs1_data_q, rs1_data_d;
  logic [XLEN-1:0] rs2_data_q, rs2_data_d;
  logic            valid_q, valid_d;
  logic            wb_en_q, wb_en_d;
  logic [4:0]      wb_reg_q, wb_reg_d;

  assign opcode    = bus.iw_in[6:0];
  assign rd        = bus.iw_in[11:7];
  assign rs1       = bus.iw_in[19:15];
  assign rs2       = bus.iw_in[24:20];
  assign is_ebreak = (bus.iw_in == EBREAK);

  assign bus.rs1_reg = rs1;
  assign bus.rs2_reg = rs2;

  rv_fwd_mux #(.XLEN(XLEN), .NUM_FWD(NUM_FWD)) u_fwd_rs1 (
    .reg_i     (rs1),
    .rf_data_i (bus.rs1_data),
    .df_en_i   (bus.df_en),
    .df_reg_i  (bus.df_reg),
    .df_data_i (bus.df_data),
    .data_o    (rs1_fwd)
  );

  rv_fwd_mux #(.XLEN(XLEN), .NUM_FWD(NUM_FWD)) u_fwd_rs2 (
    .reg_i     (rs2),
    .rf_data_i (bus.rs2_data),
    .df_en_i   (bus.df_en),
    .df_reg_i  (bus.df_reg),
    .df_data_i (bus.df_data),
    .data_o    (rs2_fwd)
  );

  // Slot 0 holds a load whose data is not available until it reaches MEM.
  assign src1_hit = rs1_used(opcode) && (rs1 != 5'd0) && (rs1 == bus.df_reg[4:0]);
  assign src2_hit = rs2_used(opcode) && (rs2 != 5'd0) && (rs2 == bus.df_reg[4:0]);
  assign load_use = bus.in_valid && bus.df_en[0] && bus.df_ex_is_load && (src1_hit || src2_hit);

  // Priority: flush > halted (unless resuming) > load-use > normal.
  always_comb begin
    state_d = state_q;
    stall   = 1'b0;
    issue   = 1'b0;
    if (bus.flush) begin
      // Kill only; FSM keeps its state.
    end else if (state_q == StHalted && !bus.resume) begin
      stall = 1'b1;
    end else begin
      state_d = StRun;
      if (load_use) begin
        stall = 1'b1;
      end else if (bus.in_valid) begin
        if (is_ebreak) begin
          state_d = StHalted;
        end else begin
          issue = 1'b1;
        end
      end
    end
  end

  always_comb begin
    iw_d       = NOP;
    pc_d       = bus.pc_in;
    valid_d    = 1'b0;
    wb_en_d    = 1'b0;
    wb_reg_d   = 5'd0;
    rs1_data_d = '0;
    rs2_data_d = '0;
    if (issue) begin
      iw_d       = bus.iw_in;
      valid_d    = 1'b1;
      wb_en_d    = (opcode != STORE) && (opcode != BRANCH) && (rd != 5'd0);
      wb_reg_d   = rd;
      rs1_data_d = rs1_fwd;
      rs2_data_d = rs2_fwd;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= StRun;
      iw_q       <= NOP;
      pc_q       <= '0;
      valid_q    <= 1'b0;
      wb_en_q    <= 1'b0;
      wb_reg_q   <= 5'd0;
      rs1_data_q <= '0;
      rs2_data_q <= '0;
    end else begin
      state_q    <= state_d;
      iw_q       <= iw_d;
      pc_q       <= pc_d;
      valid_q    <= valid_d;
      wb_en_q    <= wb_en_d;
      wb_reg_q   <= wb_reg_d;
      rs1_data_q <= rs1_data_d;
      rs2_data_q <= rs2_data_d;
    end
  end

  // Stall is forced low while reset is held so fetch is not frozen by stale state.
  assign bus.stall_out    = stall && reset;
  assign bus.halted       = (state_q == StHalted);
  assign bus.valid_out    = valid_q;
  assign bus.wb_en_out    = wb_en_q;
  assign bus.wb_reg_out   = wb_reg_q;
  assign bus.pc_out       = pc_q;
  assign bus.iw_out       = iw_q;
  assign bus.rs1_data_out = rs1_data_q;
  assign bus.rs2_data_out = rs2_data_q;

`ifdef RV_ID_PERF_EN
  logic [31:0] stall_cnt_q, stall_cnt_d;
  logic [31:0] bubble_cnt_q, bubble_cnt_d;

  always_comb begin
    stall_cnt_d  = stall_cnt_q;
    bubble_cnt_d = bubble_cnt_q;
    if (stall && stall_cnt_q != 32'hFFFF_FFFF) begin
      stall_cnt_d = stall_cnt_q + 32'd1;
    end
    if (!issue && bubble_cnt_q != 32'hFFFF_FFFF) begin
      bubble_cnt_d = bubble_cnt_q + 32'd1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stall_cnt_q  <= 32'd0;
      bubble_cnt_q <= 32'd0;
    end else begin
      stall_cnt_q  <= stall_cnt_d;
      bubble_cnt_q <= bubble_cnt_d;
    end
  end

  assign bus.stall_cnt  = stall_cnt_q;
  assign bus.bubble_cnt = bubble_cnt_q;
`endif

endmodule
